io_bus_ctrl: RTL and testbench
==============================

# io_bus_ctrl

Memory-mapped bus controller that sits directly downstream of the 16-bit RISC processor, on its `address` / `D_out` / `mw_en` / `D_in` data-memory port. It decodes each access to one of two targets: external single-port RAM, or an I/O page of registers. The I/O page holds a GPIO output latch, a GPIO input sampler, a byte-wide transmit FIFO with valid/ready drain, and a compare timer. It returns read data combinationally, because the processor has no wait state.

## Interface
- `TX_DEPTH`, default 4: transmit FIFO depth; power of two, 2..16.
- `IO_BASE`, default 16'hFF00: base of the 256-word I/O page.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 16: processor address.
- `D_out` in 16: processor write data.
- `mw_en` in 1: processor write enable.
- `D_in` out 16: read data returned to the processor; combinational.
- `ram_we` out 1: RAM write enable; equals `mw_en` when the address is a RAM address, else 0.
- `ram_rdata` in 16: asynchronous RAM read data. The RAM address and write data are `address` and `D_out` wired straight through.
- `gpio_in` in 16: external inputs.
- `gpio_out` out 16: output latch.
- `tx_data` out 8: FIFO head, low byte.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: consumer accepts the head byte.
- `irq` out 1: equals `timer_flag`.

## Operation
- **Address decode**
  - Any address with `address[15:8] != IO_BASE[15:8]` is RAM.
  - All other addresses are I/O; the register is selected by `address[2:0]`.
  - Offsets 7 and up in the I/O page read 0 and ignore writes.
- **0 GPIO_OUT (RW):** write loads `gpio_out`.
- **1 GPIO_IN (RO):** reads the `gpio_in` value captured one cycle earlier.
- **2 TX_DATA (WO):** a write pushes `D_out[7:0]`; reads return 0.
- **3 STATUS (R/W1C)**
  - Bit layout: bit0 full, bit1 empty, bits[6:2] count, bit7 `ovf`, bit8 `timer_flag`, all other bits 0.
  - Writing 1 to bit7 clears `ovf`; writing 1 to bit8 clears `timer_flag`.
- **4 TIMER_CNT (RW), 5 TIMER_CMP (RW):** 16-bit registers.
- **6 TIMER_CTRL (RW):** bit0 `tmr_en`; all other bits read 0.
- **FIFO push/pop rules**
  - A push is accepted if `count < TX_DEPTH`, or if a pop happens in the same cycle.
  - A push that is not accepted is dropped and sets `ovf` (sticky).
  - A pop happens on `tx_valid && tx_ready`.
  - Pointers wrap modulo `TX_DEPTH`.
- **Timer**
  - While `tmr_en` is 1: when `cnt == cmp`, `cnt` goes to 0 on the next edge and `timer_flag` sets; otherwise `cnt` increments.
  - A CPU write to TIMER_CNT takes priority over both the increment and the wrap.
- **Simultaneous set and W1C clear:** set wins, for both `timer_flag` and `ovf`.

## Timing
- **Reads:** `D_in` is valid in the same cycle as `address`, with zero latency.
- **Writes:** register writes take effect at the edge that ends the `mw_en` cycle; a read in the next cycle returns the new value.
- **FIFO visibility:** a pushed byte appears on `tx_data`/`tx_valid` one cycle after the push edge when the FIFO was empty.
- **FIFO hold:** `tx_data` stays stable while `tx_valid && !tx_ready`.
- **Reset values:** `gpio_out` = 0, FIFO empty (`tx_valid` = 0, `tx_data` = 0), `ovf` = 0, `cnt` = 0, `cmp` = 16'hFFFF, `tmr_en` = 0, `timer_flag` = 0, `irq` = 0.
- **Reset mid-operation:** a reset asserted during a write discards the write, and the FIFO contents are lost.
- **`ram_we` and `D_in`:** purely combinational, with no reset dependency.

## Configuration
- `IO_TIMER_EN` defined: timer registers, `timer_flag`, and `irq` are as described above.
- `IO_TIMER_EN` undefined:
  - offsets 4–6 read 0 and ignore writes;
  - STATUS bit8 reads 0;
  - `irq` is tied to 0;
  - no timer flops are synthesized.

## Structure
- **Package `io_bus_pkg`**
  - register offset constants: `GPIO_OUT_OFS` … `TIMER_CTRL_OFS`;
  - STATUS bit indices;
  - the `IO_BASE` default;
  - the `cmp` reset constant.
- **Sub-module `tx_fifo`:** parameterized by depth; provides push, pop, full, empty, count, and head. It is instantiated once.
- **Top level:** decode, read mux, GPIO, timer, and sticky bits.

## Test plan
- **RAM passthrough:** write 16'h1234 to 16'h0040 → `ram_we` = 1 for one cycle, with no I/O state change. Read 16'h0040 with `ram_rdata` = 16'hBEEF → `D_in` = 16'hBEEF.
- **GPIO:** write 16'hA5A5 to 16'hFF00 → `gpio_out` = 16'hA5A5 on the next cycle. Drive `gpio_in` = 16'h00F0 and read 16'hFF01 two cycles later → 16'h00F0.
- **FIFO fill and overflow:** hold `tx_ready` = 0 and push 5 bytes 8'h01–8'h05 with `TX_DEPTH` = 4 → STATUS = full, count 4, `ovf` = 1. Then raise `tx_ready` → bytes 01, 02, 03, 04 drain in order and `tx_valid` drops.
- **Full FIFO with push and pop in the same cycle:** push 8'h09 while `tx_ready` = 1 → count stays 4, `ovf` unchanged, and 8'h09 drains last.
- **Timer:** `cmp` = 3, `tmr_en` = 1 → `cnt` sequence 0, 1, 2, 3, 0, with `irq` rising on the wrap edge. Write STATUS 16'h0100 → `irq` = 0. A clear in the same cycle as the next set → `irq` stays 1.
- **Reset mid-traffic:** assert `reset` while the FIFO holds 2 bytes and the timer is running → next cycle all outputs are at their reset values, and STATUS = 16'h0002.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared constants for the io_bus_ctrl I/O page: register offsets, STATUS
// bit positions and reset values.
package io_bus_pkg;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;
  localparam logic [15:0] TIMER_CMP_RST   = 16'hFFFF;

  localparam logic [2:0] GPIO_OUT_OFS   = 3'd0;
  localparam logic [2:0] GPIO_IN_OFS    = 3'd1;
  localparam logic [2:0] TX_DATA_OFS    = 3'd2;
  localparam logic [2:0] STATUS_OFS     = 3'd3;
  localparam logic [2:0] TIMER_CNT_OFS  = 3'd4;
  localparam logic [2:0] TIMER_CMP_OFS  = 3'd5;
  localparam logic [2:0] TIMER_CTRL_OFS = 3'd6;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_CNT_LSB   = 2;
  localparam int STAT_OVF_BIT   = 7;
  localparam int STAT_TFLAG_BIT = 8;

  function automatic logic [15:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic [4:0] count,
                                              input logic       ovf,
                                              input logic       tflag);
    logic [15:0] s;
    s                                  = '0;
    s[STAT_FULL_BIT]                   = full;
    s[STAT_EMPTY_BIT]                  = empty;
    s[STAT_CNT_LSB +: 5]               = count;
    s[STAT_OVF_BIT]                    = ovf;
    s[STAT_TFLAG_BIT]                  = tflag;
    return s;
  endfunction

endpackage

// File: rtl/io_bus_ctrl_tx_fifo.sv
// Byte-wide transmit FIFO (power-of-two DEPTH, 2..16) with same-cycle
// push/pop on a full FIFO and a pulse for pushes that were dropped.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop, do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign count   = 5'(cnt);
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by cnt, so stale bytes are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped bus controller: RAM passthrough plus an I/O page with GPIO,
// a transmit FIFO and (when IO_TIMER_EN is defined) a compare timer with irq.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int          TX_DEPTH = 4,
  parameter logic [15:0] IO_BASE  = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [15:0] D_out,
  input  logic        mw_en,
  output logic [15:0] D_in,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  logic        is_io, reg_hit, io_we, stat_we;
  logic [2:0]  ofs;
  logic [15:0] gpio_in_q, io_rdata;
  logic        ovf, fifo_full, fifo_empty, fifo_drop;
  logic [4:0]  fifo_count;
  logic [15:0] tmr_cnt, tmr_cmp;
  logic        tmr_en, timer_flag;

  // Only the first eight words of the page hold registers; the rest read as 0.
  assign is_io   = (address[15:8] == IO_BASE[15:8]);
  assign reg_hit = is_io && (address[7:3] == 5'd0);
  assign ofs     = address[2:0];
  assign io_we   = mw_en && reg_hit;
  assign stat_we = io_we && (ofs == STATUS_OFS);
  assign ram_we  = mw_en && !is_io;

  tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (io_we && (ofs == TX_DATA_OFS)),
    .push_data (D_out[7:0]),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .dropped   (fifo_drop)
  );

  assign tx_valid = !fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out  <= '0;
      gpio_in_q <= '0;
      ovf       <= 1'b0;
    end else begin
      gpio_in_q <= gpio_in;
      if (io_we && (ofs == GPIO_OUT_OFS)) gpio_out <= D_out;
      if (fifo_drop)                          ovf <= 1'b1;
      else if (stat_we && D_out[STAT_OVF_BIT]) ovf <= 1'b0;
    end
  end

`ifdef IO_TIMER_EN
  logic tmr_hit;
  assign tmr_hit = tmr_en && (tmr_cnt == tmr_cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_cnt    <= '0;
      tmr_cmp    <= TIMER_CMP_RST;
      tmr_en     <= 1'b0;
      timer_flag <= 1'b0;
    end else begin
      if (io_we && (ofs == TIMER_CNT_OFS)) tmr_cnt <= D_out;
      else if (tmr_en)                     tmr_cnt <= tmr_hit ? 16'd0 : tmr_cnt + 16'd1;
      if (io_we && (ofs == TIMER_CMP_OFS))  tmr_cmp <= D_out;
      if (io_we && (ofs == TIMER_CTRL_OFS)) tmr_en  <= D_out[0];
      // A set in the same cycle as a W1C clear wins.
      if (tmr_hit)                               timer_flag <= 1'b1;
      else if (stat_we && D_out[STAT_TFLAG_BIT]) timer_flag <= 1'b0;
    end
  end
`else
  assign tmr_cnt    = '0;
  assign tmr_cmp    = '0;
  assign tmr_en     = 1'b0;
  assign timer_flag = 1'b0;
`endif

  assign irq = timer_flag;

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    io_rdata = '0;
    if (reg_hit) begin
      case (ofs)
        GPIO_OUT_OFS:   io_rdata = gpio_out;
        GPIO_IN_OFS:    io_rdata = gpio_in_q;
        STATUS_OFS:     io_rdata = pack_status(fifo_full, fifo_empty, fifo_count, ovf, timer_flag);
        TIMER_CNT_OFS:  io_rdata = tmr_cnt;
        TIMER_CMP_OFS:  io_rdata = tmr_cmp;
        TIMER_CTRL_OFS: io_rdata = {15'd0, tmr_en};
        default:        io_rdata = '0;
      endcase
    end
  end

  assign D_in = is_io ? io_rdata : ram_rdata;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_io_bus_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, mw_en, ram_we, tx_valid, tx_ready, irq;
  logic [15:0] address, D_out, D_in, ram_rdata, gpio_in, gpio_out;
  logic [7:0]  tx_data;

  io_bus_ctrl #(.TX_DEPTH(DEPTH), .IO_BASE(16'hFF00)) dut (
    .clk(clk), .reset(reset), .address(address), .D_out(D_out), .mw_en(mw_en),
    .D_in(D_in), .ram_we(ram_we), .ram_rdata(ram_rdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [15:0] m_gpio_out, m_gin_q, m_cnt, m_cmp;
  logic        m_ovf, m_en, m_flag;
  logic [7:0]  m_q[$];

  // Samples from the most recent cycle
  logic [15:0] s_din;
  logic        s_we, s_irq, s_valid;
  logic [7:0]  s_data;

  logic        rdy_cur = 1'b0;
  logic [15:0] gin_cur = 16'h0000;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_irq();
`ifdef IO_TIMER_EN
    return m_flag;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a, input logic [15:0] rr);
    logic [15:0] s;
    if (a[15:8] != 8'hFF) return rr;
    if (a[7:3] != 5'd0) return 16'h0000;
    case (a[2:0])
      3'd0: return m_gpio_out;
      3'd1: return m_gin_q;
      3'd3: begin
        s      = 16'h0000;
        s[0]   = (m_q.size() == DEPTH);
        s[1]   = (m_q.size() == 0);
        s[6:2] = 5'(m_q.size());
        s[7]   = m_ovf;
        s[8]   = m_irq();
        return s;
      end
`ifdef IO_TIMER_EN
      3'd4: return m_cnt;
      3'd5: return m_cmp;
      3'd6: return {15'd0, m_en};
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_reset();
    m_gpio_out = 16'h0000;
    m_gin_q    = 16'h0000;
    m_q.delete();
    m_ovf      = 1'b0;
    m_cnt      = 16'h0000;
    m_cmp      = 16'hFFFF;
    m_en       = 1'b0;
    m_flag     = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs that were applied.
  task automatic m_step(input logic [15:0] a, input logic [15:0] d, input logic we,
                        input logic rdy, input logic [15:0] gin, input logic rst);
    logic       wr, pop, hit;
    logic [2:0] o;
    int         sz;
    if (rst) begin
      m_reset();
      return;
    end
    wr  = we && (a[15:8] == 8'hFF) && (a[7:3] == 5'd0);
    o   = a[2:0];
    sz  = m_q.size();
    pop = (sz > 0) && rdy;
    hit = m_en && (m_cnt == m_cmp);
    if (pop) void'(m_q.pop_front());
    if (wr && o == 3'd2) begin
      if (sz < DEPTH || pop) m_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end else if (wr && o == 3'd3 && d[7]) begin
      m_ovf = 1'b0;
    end
    if (wr && o == 3'd0) m_gpio_out = d;
    m_gin_q = gin;
`ifdef IO_TIMER_EN
    if (wr && o == 3'd4) m_cnt = d;
    else if (m_en) m_cnt = hit ? 16'h0000 : m_cnt + 16'h0001;
    if (wr && o == 3'd5) m_cmp = d;
    if (hit) m_flag = 1'b1;
    else if (wr && o == 3'd3 && d[8]) m_flag = 1'b0;
    if (wr && o == 3'd6) m_en = d[0];
`endif
  endtask

  // Called 1 time unit after a rising edge; ends 1 time unit after the next one.
  task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic we,
                       input logic rdy, input logic [15:0] gin, input logic [15:0] rr,
                       input logic rst);
    address = a; D_out = d; mw_en = we; tx_ready = rdy; gpio_in = gin;
    ram_rdata = rr; reset = rst;
    #3;
    s_din = D_in; s_we = ram_we; s_irq = irq; s_valid = tx_valid; s_data = tx_data;
    check("d_in", D_in, m_read(a, rr));
    check("ram_we", ram_we, we && (a[15:8] != 8'hFF));
    check("gpio_out", gpio_out, m_gpio_out);
    check("tx_valid", tx_valid, m_q.size() != 0);
    check("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
    check("irq", irq, m_irq());
    @(posedge clk);
    m_step(a, d, we, rdy, gin, rst);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cycle(a, d, 1'b1, rdy_cur, gin_cur, 16'($urandom), 1'b0);
  endtask

  task automatic rd(input logic [15:0] a);
    cycle(a, 16'($urandom), 1'b0, rdy_cur, gin_cur, 16'($urandom), 1'b0);
  endtask

  initial begin
    logic [15:0] a, d;
    logic [15:0] exp_cnt [5];
    logic        exp_irq [5];
    int          r;

    address = '0; D_out = '0; mw_en = 1'b0; tx_ready = 1'b0; gpio_in = '0;
    ram_rdata = '0; reset = 1'b1;
    repeat (2) @(posedge clk);
    m_reset();
    #1;

    // Reset state
    rd(16'hFF03);
    check("rst_status", s_din, 16'h0002);
    check("rst_gpio", gpio_out, 16'h0000);
    check("rst_valid", s_valid, 1'b0);
    check("rst_data", s_data, 8'h00);
    check("rst_irq", s_irq, 1'b0);
`ifdef IO_TIMER_EN
    rd(16'hFF05);
    check("rst_cmp", s_din, 16'hFFFF);
`endif

    // RAM passthrough
    cycle(16'h0040, 16'h1234, 1'b1, 1'b0, gin_cur, 16'h0000, 1'b0);
    check("ram_we_wr", s_we, 1'b1);
    cycle(16'h0040, 16'h0000, 1'b0, 1'b0, gin_cur, 16'hBEEF, 1'b0);
    check("ram_rd", s_din, 16'hBEEF);
    check("ram_we_rd", s_we, 1'b0);
    check("ram_no_io", gpio_out, 16'h0000);

    // GPIO
    wr(16'hFF00, 16'hA5A5);
    rd(16'hFF00);
    check("gpio_new", gpio_out, 16'hA5A5);
    check("gpio_rd", s_din, 16'hA5A5);
    gin_cur = 16'h00F0;
    rd(16'h0000);
    rd(16'h0000);
    rd(16'hFF01);
    check("gpio_in", s_din, 16'h00F0);

    // FIFO fill and overflow
    rdy_cur = 1'b0;
    for (int i = 1; i <= 5; i++) wr(16'hFF02, 16'(i));
    rd(16'hFF03);
    check("fill_status", s_din, 16'h0091);
    check("fill_head", s_data, 8'h01);
    rdy_cur = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rd(16'h0010);
      check("drain_valid", s_valid, 1'b1);
      check("drain_data", s_data, 8'(i));
    end
    rd(16'h0010);
    check("drain_empty", s_valid, 1'b0);
    rdy_cur = 1'b0;
    wr(16'hFF03, 16'h0080);
    rd(16'hFF03);
    check("ovf_clr", s_din, 16'h0002);

    // Full FIFO with push and pop in the same cycle
    for (int i = 5; i <= 8; i++) wr(16'hFF02, 16'(i));
    cycle(16'hFF02, 16'h0009, 1'b1, 1'b1, gin_cur, 16'h0000, 1'b0);
    rd(16'hFF03);
    check("pp_status", s_din, 16'h0011);
    rdy_cur = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      rd(16'h0020);
      check("pp_data", s_data, 8'(i));
    end
    rd(16'h0020);
    check("pp_empty", s_valid, 1'b0);
    rdy_cur = 1'b0;

`ifdef IO_TIMER_EN
    // Timer wrap, W1C clear, and set-beats-clear
    exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    wr(16'hFF05, 16'd3);
    wr(16'hFF04, 16'd0);
    wr(16'hFF06, 16'd1);
    for (int i = 0; i < 5; i++) begin
      rd(16'hFF04);
      check("tmr_cnt", s_din, exp_cnt[i]);
      check("tmr_irq", s_irq, exp_irq[i]);
    end
    wr(16'hFF03, 16'h0100);
    rd(16'hFF03);
    check("irq_clr", s_irq, 1'b0);
    wr(16'hFF03, 16'h0100);
    rd(16'hFF03);
    check("irq_set_wins", s_irq, 1'b1);
`endif

    // Reset mid-traffic
    wr(16'hFF02, 16'h00AA);
    wr(16'hFF02, 16'h00BB);
    wr(16'hFF00, 16'h1111);
    cycle(16'hFF00, 16'hFFFF, 1'b1, 1'b0, gin_cur, 16'h0000, 1'b1);
    rd(16'hFF03);
    check("mid_status", s_din, 16'h0002);
    check("mid_gpio", gpio_out, 16'h0000);
    check("mid_valid", s_valid, 1'b0);
    check("mid_data", s_data, 8'h00);
    check("mid_irq", s_irq, 1'b0);
`ifdef IO_TIMER_EN
    rd(16'hFF05);
    check("mid_cmp", s_din, 16'hFFFF);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      a = {8'hFF, 5'd0, 3'($urandom_range(0, 7))};
      else if (r < 65) a = {8'hFF, 8'($urandom)};
      else             a = 16'($urandom);
      d = 16'($urandom);
      if (a[15:3] == 13'h1FE0 && a[2:0] == 3'd5) d = 16'($urandom_range(0, 20));
      if (a[15:3] == 13'h1FE0 && a[2:0] == 3'd4) d = 16'($urandom_range(0, 10));
      gin_cur = 16'($urandom);
      cycle(a, d, 1'($urandom), 1'($urandom_range(0, 3) == 0), gin_cur,
            16'($urandom), $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
